// File: rtl/pof_norm_pkg.sv
// Shared widths and count types for the leading-sign-count pipeline.
package pof_norm_pkg;
    localparam int DATA_WIDTH  = 64;
    localparam int SEG_WIDTH   = 16;
    localparam int NUM_SEG     = DATA_WIDTH / SEG_WIDTH;
    localparam int COUNT_WIDTH = 6;

    typedef logic [4:0]             seg_count_t;
    typedef logic [COUNT_WIDTH-1:0] lsc_count_t;
endpackage

// File: rtl/lsc_segment.sv
// Counts leading bits of one segment that match the operand sign (0..16).
module lsc_segment
    import pof_norm_pkg::*;
(
    input  logic [SEG_WIDTH-1:0] seg_i,
    input  logic                 sign_i,
    output seg_count_t           count_o
);
    logic run;

    always_comb begin
        count_o = '0;
        run     = 1'b1;
        for (int i = SEG_WIDTH - 1; i >= 0; i--) begin
            if (run && (seg_i[i] == sign_i)) begin
                count_o = count_o + seg_count_t'(1);
            end else begin
                run = 1'b0;
            end
        end
    end
endmodule

// File: rtl/leading_sign_count_pipe.sv
// Two-stage redundant-sign-bit counter with valid/ready flow control.
module leading_sign_count_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int SEG_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [5:0]            m_count,
    output logic                  m_allsign,
    output logic                  m_sign,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);
    import pof_norm_pkg::*;

    logic                            v1_q, v2_q;
    logic                            ld1, ld2;
    logic                            sign1_q;
    logic [DATA_WIDTH-1:0]           data1_q;
    seg_count_t [NUM_SEG-1:0]        cnt1_q, cnt1_d;
    logic [COUNT_WIDTH:0]            tot;
    logic                            run;
    lsc_count_t                      count_d, count_q;
    logic                            allsign_d, allsign_q;
    logic                            sign2_q;
    logic [DATA_WIDTH-1:0]           data2_q;

    assign ld2     = !v2_q || m_ready;
    assign ld1     = !v1_q || ld2;
    assign s_ready = ld1;

    for (genvar g = 0; g < NUM_SEG; g++) begin : g_seg
        lsc_segment u_seg (
            .seg_i   (s_data[g*SEG_WIDTH +: SEG_WIDTH]),
            .sign_i  (s_data[DATA_WIDTH-1]),
            .count_o (cnt1_d[g])
        );
    end

    // Sum full segments from the MSB down; the first partial one ends the run.
    always_comb begin
        tot = '0;
        run = 1'b1;
        for (int s = NUM_SEG - 1; s >= 0; s--) begin
            if (run) begin
                tot = tot + (COUNT_WIDTH+1)'(cnt1_q[s]);
                if (cnt1_q[s] != seg_count_t'(SEG_WIDTH)) run = 1'b0;
            end
        end
        count_d   = lsc_count_t'(tot - 1'b1);
        allsign_d = (tot == (COUNT_WIDTH+1)'(DATA_WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            data1_q <= '0;
            cnt1_q  <= '0;
        end else if (ld1) begin
            v1_q <= s_valid;
            if (s_valid) begin
                sign1_q <= s_data[DATA_WIDTH-1];
                data1_q <= s_data;
                cnt1_q  <= cnt1_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q      <= 1'b0;
            count_q   <= '0;
            allsign_q <= 1'b0;
            sign2_q   <= 1'b0;
            data2_q   <= '0;
        end else if (ld2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                count_q   <= count_d;
                allsign_q <= allsign_d;
                sign2_q   <= sign1_q;
                data2_q   <= data1_q;
            end
        end
    end

    assign m_valid   = v2_q;
    assign m_count   = count_q;
    assign m_allsign = allsign_q;
    assign m_sign    = sign2_q;
    assign m_data    = data2_q;
endmodule

// File: tb/tb_leading_sign_count_pipe.sv
// Scoreboard bench: directed corners, back-pressure, reset flush, random stream.
module tb_leading_sign_count_pipe;
    typedef struct packed {
        logic [5:0]  c;
        logic        a;
        logic        s;
        logic [63:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [5:0]  m_count;
    logic        m_allsign;
    logic        m_sign;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;

    int total = 0;
    int bad = 0;
    exp_t exp_q[$];
    logic held = 1'b0;
    exp_t hv;

    always #5 clk = ~clk;

    leading_sign_count_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_count   (m_count),
        .m_allsign (m_allsign),
        .m_sign    (m_sign),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    function automatic exp_t model(input logic [63:0] d);
        exp_t e;
        int   n = 0;
        bit   run = 1'b1;
        for (int i = 63; i >= 0; i--) begin
            if (run && d[i] == d[63]) n++;
            else run = 1'b0;
        end
        e.c = 6'(n - 1);
        e.a = (n == 64);
        e.s = d[63];
        e.d = d;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cyc(input logic v, input logic [63:0] d, input logic rdy,
                       input exp_t e, output logic acc);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        m_ready = rdy;
        #1;
        acc = v && s_ready;
        if (acc) exp_q.push_back(e);
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        cyc(1'b0, {$urandom, $urandom}, rdy, '0, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        idle(1'b1);
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops on every output handshake, checks holds under back-pressure.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_out", {m_count, m_allsign, m_sign, 56'd0} ^ m_data,
                    {hv.c, hv.a, hv.s, 56'd0} ^ hv.d);
            end
            if (m_valid && m_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got data %h with nothing expected", m_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", m_data, e.d);
                    chk("out_count", 64'(m_count), 64'(e.c));
                    chk("out_flags", {62'd0, m_allsign, m_sign}, {62'd0, e.a, e.s});
                end
            end else if (m_valid) begin
                held = 1'b1;
                hv.c = m_count;
                hv.a = m_allsign;
                hv.s = m_sign;
                hv.d = m_data;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        logic        acc;
        logic [63:0] dd [10];
        exp_t        ee [10];
        int          n;

        dd[0] = 64'h0000_0000_0000_0001; ee[0] = '{6'd62, 1'b0, 1'b0, dd[0]};
        dd[1] = 64'h8000_0000_0000_0000; ee[1] = '{6'd0,  1'b0, 1'b1, dd[1]};
        dd[2] = 64'hC000_0000_0000_0000; ee[2] = '{6'd1,  1'b0, 1'b1, dd[2]};
        dd[3] = 64'h0000_0000_0000_8000; ee[3] = '{6'd47, 1'b0, 1'b0, dd[3]};
        dd[4] = 64'h4000_0000_0000_0000; ee[4] = '{6'd0,  1'b0, 1'b0, dd[4]};
        dd[5] = 64'h0;                   ee[5] = '{6'd63, 1'b1, 1'b0, dd[5]};
        dd[6] = 64'hFFFF_FFFF_FFFF_FFFF; ee[6] = '{6'd63, 1'b1, 1'b1, dd[6]};
        dd[7] = 64'hFFFF_0000_0000_0000; ee[7] = '{6'd15, 1'b0, 1'b1, dd[7]};
        dd[8] = 64'h0000_0000_0001_0000; ee[8] = '{6'd46, 1'b0, 1'b0, dd[8]};
        dd[9] = 64'hFFFF_FFFF_FFFF_7FFF; ee[9] = '{6'd47, 1'b0, 1'b1, dd[9]};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_out", {m_count, m_allsign, m_sign, 56'd0} | m_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready", 64'(s_ready), 64'd1);

        // Latency: accepted at one edge, visible after the second edge.
        cyc(1'b1, dd[0], 1'b1, ee[0], acc);
        chk("lat_acc", 64'(acc), 64'd1);
        idle(1'b1);
        chk("lat_c1", 64'(m_valid), 64'd0);
        idle(1'b1);
        chk("lat_c2", 64'(m_valid), 64'd1);
        drain();

        for (int i = 1; i < 10; i++) begin
            cyc(1'b1, dd[i], 1'b1, ee[i], acc);
            chk("dir_acc", 64'(acc), 64'd1);
        end
        drain();

        // Back-pressure: three back-to-back operands, four cycles stalled.
        cyc(1'b1, dd[3], 1'b0, ee[3], acc);
        chk("bp_acc1", 64'(acc), 64'd1);
        cyc(1'b1, dd[6], 1'b0, ee[6], acc);
        chk("bp_acc2", 64'(acc), 64'd1);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, dd[2], 1'b0, ee[2], acc);
            chk("bp_s_ready_low", 64'(acc), 64'd0);
        end
        n = 0;
        acc = 1'b0;
        while (!acc && n < 8) begin
            cyc(1'b1, dd[2], 1'b1, ee[2], acc);
            n++;
        end
        chk("bp_acc3", 64'(acc), 64'd1);
        drain();

        // Reset with two operands in flight.
        cyc(1'b1, dd[1], 1'b0, ee[1], acc);
        cyc(1'b1, dd[4], 1'b0, ee[4], acc);
        idle(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("rstm_valid", 64'(m_valid), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstm_s_ready", 64'(s_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("rstm_quiet", 64'(m_valid), 64'd0);
        end

        // Random stream against the reference model.
        n = 0;
        for (int cy = 0; cy < 60000 && n < 10000; cy++) begin
            logic [63:0] r;
            logic [63:0] d;
            logic        v;
            r = {$urandom, $urandom};
            d = 64'($signed(r) >>> $urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) d = {64{r[0]}};
            v = ($urandom_range(0, 9) < 7);
            cyc(v, d, ($urandom_range(0, 9) < 6), model(d), acc);
            if (acc) n++;
        end
        chk("rand_count", 64'(n), 64'd10000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/leading_sign_count_pipe.md
LEADING_SIGN_COUNT_PIPE -- requirements
Module: leading_sign_count_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of the signed input operand; only 64 is supported.
REQ-002 Parameter SEG_WIDTH, default 16: width of one stage-1 counting segment; DATA_WIDTH/SEG_WIDTH = 4 segments.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assertion and active-low; there is one clock.
REQ-005 Port s_data, input, 64: two's-complement operand to normalise.
REQ-006 Port s_valid, input, 1: s_data is valid this cycle.
REQ-007 Port s_ready, output, 1: the block accepts s_data this cycle.
REQ-008 Port m_count, output, 6: redundant-sign-bit count; this is the 6-bit index consumed by the downstream signed shift LUT.
REQ-009 Port m_allsign, output, 1: the operand was all-zeros or all-ones.
REQ-010 Port m_sign, output, 1: s_data[63] of the operand.
REQ-011 Port m_data, output, 64: the operand, passed through unchanged and aligned with m_count.
REQ-012 Port m_valid, output, 1: the m_* outputs are valid.
REQ-013 Port m_ready, input, 1: the downstream stage accepts the m_* outputs.

Function
REQ-014 m_count SHALL equal (number of leading bits of the operand equal to bit 63) minus 1, with range 0..63.
REQ-015 All-zeros and all-ones operands SHALL give m_count=63 and m_allsign=1; all other operands SHALL give m_allsign=0.
REQ-016 Stage 1 SHALL register, per 16-bit segment, a 5-bit count (0..16) of leading bits equal to s_data[63], together with the sign and the data.
REQ-017 Stage 2 SHALL combine the segment counts MSB-first, summing through each segment whose count is 16 and stopping at the first partial one, then subtract 1, register the result and drive m_*.
REQ-018 Latency SHALL be exactly 2 cycles from the s_valid&&s_ready handshake to m_valid, provided m_ready is held high.
REQ-019 Throughput SHALL be 1 operand per cycle while m_ready=1.
REQ-020 Stage 2 SHALL load when (!v2 || m_ready); stage 1 SHALL load when (!v1 || stage 2 loads).
REQ-021 s_ready SHALL equal (!v1 || stage 2 loads); a combinational path from m_ready to s_ready is permitted.
REQ-022 While m_valid && !m_ready, every m_* output SHALL hold stable, and no operand SHALL be dropped or duplicated.
REQ-023 Bubbles SHALL collapse: an empty stage 2 SHALL load from stage 1 regardless of m_ready.
REQ-024 s_valid SHALL be ignored when s_ready=0, and s_data SHALL be ignored when s_valid=0.
REQ-025 The valid flags SHALL be v1 = s_valid&&s_ready latched on each stage-1 load, and v2 = v1 latched on each stage-2 load.

Reset
REQ-026 While rst_n=0: v1=v2=0, m_valid=0, m_count=0, m_allsign=0, m_sign=0, m_data=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operands, with no m_valid pulse after release.
REQ-028 In the first cycle after release, s_ready SHALL be 1.

Structure
REQ-029 Package pof_norm_pkg SHALL hold the constants DATA_WIDTH, SEG_WIDTH, NUM_SEG and COUNT_WIDTH=6, and the typedefs seg_count_t (5-bit) and lsc_count_t (6-bit).
REQ-030 Sub-module lsc_segment SHALL be purely combinational, with inputs of one 16-bit segment plus the sign bit and output seg_count_t, and SHALL be instantiated 4 times in stage 1.

Verification
REQ-031 With m_ready=1, 0x0000_0000_0000_0001 SHALL give m_count=62, m_allsign=0, m_sign=0, with m_valid exactly 2 cycles later.
REQ-032 0x8000_0000_0000_0000 SHALL give m_count=0; 0xC000_0000_0000_0000 SHALL give 1; 0x0000_0000_0000_8000 SHALL give 47; 0x4000_0000_0000_0000 SHALL give 0.
REQ-033 0 SHALL give m_count=63 and m_allsign=1; 0xFFFF_FFFF_FFFF_FFFF SHALL give m_count=63, m_allsign=1, m_sign=1.
REQ-034 Back-to-back stream of 3 operands with m_ready held 0 for 4 cycles: s_ready SHALL drop after 2 accepts, outputs SHALL be held, and all 3 results SHALL emerge in order once m_ready=1.
REQ-035 rst_n pulsed low while 2 operands are in flight: m_valid SHALL be 0 immediately and SHALL stay 0 until new input.
REQ-036 Random 10k operands with a random m_ready pattern SHALL match a reference count model and in-order scoreboard.
